// File: rtl/sq_pkg.sv
// Shared definitions for the sequential squarer.
// Contents:
//   SqWidth    default operand width
//   sq_state_e controller states (idle / iterating / result held)
package sq_pkg;

   localparam int unsigned SqWidth = 16;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } sq_state_e;

endpackage

// File: rtl/sq_shift_add_step.sv
// One combinational iteration of the shift-add multiply used by seq_square.
// Ports:
//   acc_i / acc_o       2*WIDTH-bit partial sum, current / next
//   mcand_i / mcand_o   2*WIDTH-bit shifted multiplicand, current / next
//   mplier_i / mplier_o WIDTH-bit multiplier, consumed LSB first, current / next
module sq_shift_add_step
   import sq_pkg::*;
#(
   parameter int unsigned WIDTH = SqWidth
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [2*WIDTH-1:0] mcand_i,
   input  logic [WIDTH-1:0]   mplier_i,
   output logic [2*WIDTH-1:0] acc_o,
   output logic [2*WIDTH-1:0] mcand_o,
   output logic [WIDTH-1:0]   mplier_o
);

   always_comb begin
      acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
      mcand_o  = mcand_i << 1;
      mplier_o = mplier_i >> 1;
   end

endmodule

// File: rtl/seq_square.sv
// Sequential shift-add squarer: out_sq_o = in_x_i * in_x_i, one multiplier bit per clock.
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   in_valid_i   operand valid           in_ready_o  operand accepted (idle, not in reset)
//   in_x_i       unsigned operand
//   out_valid_o  result valid            out_ready_i downstream takes the result
//   out_sq_o     2*WIDTH-bit square, stable while out_valid_o is high
//   busy_o       an operand is in flight (not idle, not in reset)
// Build option:
//   SQUARE_EARLY_EXIT_EN  finish as soon as the remaining multiplier bits are all zero;
//                         a zero operand completes at the accept edge. Undefined: every
//                         operand takes exactly WIDTH iterations.
module seq_square
   import sq_pkg::*;
#(
   parameter int unsigned WIDTH = SqWidth
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   in_x_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [2*WIDTH-1:0] out_sq_o,
   output logic               busy_o
);

   localparam int unsigned     CntW    = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   sq_state_e          state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] out_sq_q, out_sq_d;

   logic [2*WIDTH-1:0] acc_nxt;
   logic [2*WIDTH-1:0] mcand_nxt;
   logic [WIDTH-1:0]   mplier_nxt;

   sq_shift_add_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc_i    (acc_q),
      .mcand_i  (mcand_q),
      .mplier_i (mplier_q),
      .acc_o    (acc_nxt),
      .mcand_o  (mcand_nxt),
      .mplier_o (mplier_nxt)
   );

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      out_sq_d = out_sq_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               mcand_d  = {{WIDTH{1'b0}}, in_x_i};
               mplier_d = in_x_i;
               acc_d    = '0;
               cnt_d    = '0;
`ifdef SQUARE_EARLY_EXIT_EN
               if (in_x_i == '0) begin
                  out_sq_d = '0;
                  state_d  = StDone;
               end else begin
                  state_d  = StCalc;
               end
`else
               state_d  = StCalc;
`endif
            end
         end
         StCalc: begin
            acc_d    = acc_nxt;
            mcand_d  = mcand_nxt;
            mplier_d = mplier_nxt;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               out_sq_d = acc_nxt;
               state_d  = StDone;
            end
`ifdef SQUARE_EARLY_EXIT_EN
            // No set bits left: the remaining iterations would not change acc.
            else if (mplier_nxt == '0) begin
               out_sq_d = acc_nxt;
               state_d  = StDone;
            end
`endif
         end
         StDone: begin
            if (out_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         out_sq_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         out_sq_q <= out_sq_d;
      end
   end

   // Handshake-facing status is forced low for as long as reset is asserted.
   assign in_ready_o  = (state_q == StIdle) && !rst_i;
   assign busy_o      = (state_q != StIdle) && !rst_i;
   assign out_valid_o = (state_q == StDone);
   assign out_sq_o    = out_sq_q;

endmodule

// File: tb/tb_seq_square.sv
// Directed plus randomized bench for seq_square (default build, WIDTH = 16).
module tb_seq_square;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_x;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sq;
   logic        busy;

   int checks = 0;
   int errors = 0;

   seq_square #(
      .WIDTH (16)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_x_i      (in_x),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_sq_o    (out_sq),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: the square is plain integer arithmetic; latency is a fixed 16 edges.
   task automatic run_txn(input logic [15:0] x, input int hold);
      longint      exp_sq;
      int          lat;
      int          wait_cnt;
      bit          ready_leak;
      logic [31:0] held;
      exp_sq = longint'(x) * longint'(x);
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 50) begin
         step();
         wait_cnt++;
      end
      check("in_ready_idle", 64'(in_ready), 64'd1);
      in_x     = x;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("busy_after_accept", 64'(busy), 64'd1);
      lat        = 0;
      ready_leak = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) ready_leak = 1'b1;
         in_valid  = 1'($urandom);
         in_x      = 16'($urandom);
         out_ready = 1'($urandom);
         step();
         lat++;
      end
      in_valid = 1'b0;
      check("in_ready_low_calc", 64'(ready_leak), 64'd0);
      check("latency", 64'(lat), 64'd16);
      check("out_sq", 64'(out_sq), 64'(exp_sq));
      held = out_sq;
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         in_valid  = 1'($urandom);
         in_x      = 16'($urandom);
         step();
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_sq", 64'(out_sq), 64'(held));
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("valid_drop", 64'(out_valid), 64'd0);
      check("in_ready_after", 64'(in_ready), 64'd1);
   endtask

   initial begin
      bit seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_x      = '0;
      step();
      step();
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_sq", 64'(out_sq), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_busy", 64'(busy), 64'd0);

      run_txn(16'h0010, 0);
      // Back-to-back sequence.
      run_txn(16'd9, 0);
      run_txn(16'd1, 0);
      run_txn(16'd3, 0);
      run_txn(16'hFFFF, 0);
      run_txn(16'h0000, 0);
      // Backpressure with ignored in_valid pulses.
      run_txn(16'($urandom), 10);

      // Reset 5 edges after accepting 100 aborts the operation.
      in_x     = 16'd100;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      step();
      rst = 1'b0;
      #1;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_out_sq", 64'(out_sq), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      seen = 1'b0;
      out_ready = 1'b1;
      repeat (30) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      out_ready = 1'b0;
      check("no_result_after_abort", 64'(seen), 64'd0);
      run_txn(16'd7, 2);

      for (int n = 0; n < 25; n++) begin
         run_txn(16'($urandom), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
